// File: rtl/instr_fetch_queue.sv
// Byte-to-halfword instruction assembler with a small tagged FIFO.
// Bytes arrive low-first; each completed pair is queued and handed to the
// core over valid/ready, tagged with a running fetch index (pc_tag).
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             flush,
    input  logic [7:0]       flush_pc,
    output logic [15:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [7:0]       pc_tag,
    output logic [PTR_W:0]   count,
    output logic             overrun
);

    typedef enum logic {LOW_BYTE = 1'b0, HIGH_BYTE = 1'b1} half_e;

    logic [PTR_W:0]              wr_q, wr_d, rd_q, rd_d;
    half_e                       half_q, half_d;
    logic [7:0]                  low_q, low_d;
    logic [DEPTH-1:0][15:0]      mem_q, mem_d;
    logic [7:0]                  pc_q, pc_d;
    logic                        overrun_q, overrun_d;

    logic full, empty, accept, pop;

    // Occupancy from extra-MSB pointers; ready is a pure function of full.
    always_comb begin
        full        = (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]) && (wr_q[PTR_W] != rd_q[PTR_W]);
        empty       = (wr_q == rd_q);
        byte_ready  = !full;
        instr_valid = !empty;
        instr       = mem_q[rd_q[PTR_W-1:0]];
        count       = wr_q - rd_q;
        pc_tag      = pc_q;
        overrun     = overrun_q;
        accept      = byte_valid && byte_ready;
        pop         = instr_valid && instr_ready;
    end

    // Next-state: flush overrides any same-cycle accept or pop.
    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        half_d    = half_q;
        low_d     = low_q;
        mem_d     = mem_q;
        pc_d      = pc_q;
        overrun_d = overrun_q;
        if (flush) begin
            wr_d      = '0;
            rd_d      = '0;
            half_d    = LOW_BYTE;
            overrun_d = 1'b0;
            pc_d      = flush_pc;
        end else begin
            if (byte_valid && !byte_ready)
                overrun_d = 1'b1;
            if (accept) begin
                if (half_q == LOW_BYTE) begin
                    low_d  = byte_in;
                    half_d = HIGH_BYTE;
                end else begin
                    mem_d[wr_q[PTR_W-1:0]] = {byte_in, low_q};
                    wr_d   = wr_q + (PTR_W+1)'(1);
                    half_d = LOW_BYTE;
                end
            end
            if (pop) begin
                rd_d = rd_q + (PTR_W+1)'(1);
                pc_d = pc_q + 8'd1;
            end
        end
    end

    // State registers; storage is cleared only by reset, never by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            half_q    <= LOW_BYTE;
            low_q     <= '0;
            mem_q     <= '0;
            pc_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            half_q    <= half_d;
            low_q     <= low_d;
            mem_q     <= mem_d;
            pc_q      <= pc_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Upstream fetch stage for the 8-bit mini RISC core. Assembles 16-bit instructions from a byte-wide input stream (low byte first), buffers them in a small FIFO, and presents them to the core over a valid/ready handshake. Tags each queued instruction with its fetch index, and supports a synchronous flush with a new start index for branch redirects.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, 2..8.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- byte_in  in  8  instruction byte; first byte of a pair = instr[7:0], second = instr[15:8].
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  block accepts a byte this cycle; equals !full.
- flush  in  1  synchronous discard of all queued and partial state.
- flush_pc  in  8  fetch index loaded into pc_tag on flush.
- instr  out  16  head-of-queue instruction.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  core consumes head when instr_valid && instr_ready.
- pc_tag  out  8  fetch index of the head instruction.
- count  out  PTR_W+1  occupied entries, 0..DEPTH.
- overrun  out  1  sticky: a byte was offered while byte_ready was low.

## Operation
- Byte accept: byte_valid && byte_ready. The half flag toggles on each accept. On the first accept, the byte latches into the low-byte register. On the second accept, {byte_in, low} pushes into the FIFO at the write pointer.
- Pop: instr_valid && instr_ready. The read pointer advances, and pc_tag increments modulo 256 (0xFF -> 0x00).
- Pointers are PTR_W+1 bits and wrap naturally.
  - full = (wr[PTR_W-1:0]==rd[PTR_W-1:0]) && (wr[PTR_W]!=rd[PTR_W]).
  - empty = (wr==rd).
  - count = wr - rd.
- byte_ready depends on full only; it is low when full, even while half=0. There is no bypass from a pop in the same cycle.
- Push and pop in the same cycle (non-empty, non-full): both take effect and count is unchanged.
- instr = mem[rd]. It is combinational from registered storage and must stay stable while instr_valid && !instr_ready.
- Flush (highest priority, synchronous):
  - Write/read pointers and half are cleared; overrun is cleared; pc_tag <= flush_pc.
  - A byte accepted in the same cycle is discarded.
  - A pop in the same cycle is ignored, so pc_tag = flush_pc and not flush_pc+1.
- overrun is set when byte_valid && !byte_ropeady; it is cleared only by flush or rst.
- Storage contents are cleared on rst, not on flush.
- No internal FSM beyond the half flag (states LOW_BYTE / HIGH_BYTE: LOW -> HIGH on accept, HIGH -> LOW on accept, any -> LOW on flush/rst).

## Timing
- Reset values (immediate on rst assertion):
  - byte_ready=1, instr_valid=0, instr=0x0000.
  - pc_tag=0x00, count=0, overrun=0, half=LOW_BYTE.
- Latency: when the second byte is accepted at edge N, instr_valid=1 and count increments from cycle N+1 (after edge N). The byte is never visible in the same cycle.
- Pop at edge N: the next entry (or instr_valid=0) appears after edge N.
- Throughput: one instruction per 2 byte cycles in, one per cycle out.
- Flush asserted at edge N: instr_valid=0, count=0, byte_ready=1 after edge N. A byte accepted at edge N+1 is a low byte.
- rst deassertion is synchronised externally; the block makes no assumption about which edge it arrives on.

## Test plan
- Reset, then bytes 0x21, 0x04 on consecutive cycles with instr_ready=0 -> after the second edge: instr=0x0421, instr_valid=1, count=1, pc_tag=0x00.
- Push 4 instructions 0x0001..0x0004 with instr_ready=0 -> count=4, byte_ready=0. Extra byte 0x55 -> overrun=1, count stays 4. Drain with instr_ready=1 -> 0x0001..0x0004 in order, pc_tag 0,1,2,3, then instr_valid=0.
- count=2; push the second byte and pop on the same edge -> count stays 2, pc_tag+1.
- Low byte 0xAA accepted, then flush with flush_pc=0x10 -> count=0, overrun=0. Next bytes 0x01, 0x02 -> instr=0x0201, pc_tag=0x10.
- Flush coincident with pop and second-byte accept, flush_pc=0x80 -> pc_tag=0x80, count=0, instr_valid=0. pc_tag wrap: flush_pc=0xFF, one pop -> 0x00.
- Assert rst asynchronously mid-stream (count=3, half=HIGH_BYTE) -> all outputs take reset values before the next clk edge. A fresh pair afterwards yields count=1 with the correct low/high order.
